// File: rtl/memory_bus_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_e : arbitration FSM states (drain after reset, idle, issue, wait for response)
//   BHW_*       : legal transfer-size codes understood by memory_top
//   bhw_legal() : true for a size code memory_top can complete
package memory_bus_pkg;

    typedef enum logic [1:0] {
        StDrain = 2'd0,
        StIdle  = 2'd1,
        StIssue = 2'd2,
        StWait  = 2'd3
    } arb_state_e;

    localparam logic [2:0] BHW_BYTE = 3'b001;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_WORD = 3'b100;

    // memory_top never answers any other code, so forwarding one would hang the bus.
    function automatic logic bhw_legal(input logic [2:0] bhw);
        return (bhw == BHW_BYTE) || (bhw == BHW_HALF) || (bhw == BHW_WORD);
    endfunction

endpackage

// File: rtl/bus_request_slot.sv
// One-deep request capture register for a single bus master.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   req_i             : one-cycle request pulse; captured only when the slot is free or being
//                       cleared in the same cycle
//   clr_i             : releases the slot (the master's response cycle)
//   addr_i .. write_i : request fields captured on an accepted pulse
//   busy_o            : slot occupied
//   addr_o .. write_o : captured request fields
module bus_request_slot (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        clr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  bhw_i,
    input  logic        write_i,
    output logic        busy_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [2:0]  bhw_o,
    output logic        write_o
);

    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  bhw_q, bhw_d;
    logic        write_q, write_d;
    logic        load;

    // A pulse landing in the response cycle refills the slot as it empties.
    assign load = req_i && (!valid_q || clr_i);

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        bhw_d   = bhw_q;
        write_d = write_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
            bhw_d   = bhw_i;
            write_d = write_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            bhw_q   <= '0;
            write_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            bhw_q   <= bhw_d;
            write_q <= write_d;
        end
    end

    assign busy_o  = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign bhw_o   = bhw_q;
    assign write_o = write_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter in front of memory_top's single-transaction bus.
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_mN_*  (N = 0, 1)    : request pulse and fields from master N (0 = CPU, 1 = SD/DMA loader)
//   o_mN_data/DV/err      : registered response to master N; err marks a rejected size code
//   o_mN_busy             : master N's request slot is occupied
//   o_mem_*               : registered request to memory_top, fields hold between issues
//   i_mem_data, i_mem_DV  : response from memory_top
// After reset the FSM waits in drain for a stray response, since memory_top itself has no reset.
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 64,
    parameter bit          ROUND_ROBIN  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_DV,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic        o_m0_err,
    output logic        o_m0_busy,

    input  logic        i_m1_DV,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic        o_m1_err,
    output logic        o_m1_busy,

    output logic        o_mem_DV,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_data,
    output logic [2:0]  o_mem_bhw,
    output logic        o_mem_write,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_DV
);

    // DRAIN_CYCLES must be at least 1.
    localparam int unsigned       DrainW    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    logic [1:0]  slot_busy;
    logic [1:0]  slot_write;
    logic [31:0] slot_addr [2];
    logic [31:0] slot_data [2];
    logic [2:0]  slot_bhw  [2];

    arb_state_e        state_q;
    logic [DrainW-1:0] drain_cnt_q;
    logic              last_q;
    logic              gnt_q;

    logic [1:0]  rsp_dv_q;
    logic [1:0]  rsp_err_q;
    logic [31:0] rsp_data_q [2];

    logic        mem_dv_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic [2:0]  mem_bhw_q;
    logic        mem_write_q;

    logic [1:0]  elig;
    logic        gnt_sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic [2:0]  sel_bhw;
    logic        sel_write;

    bus_request_slot u_slot0 (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .req_i   (i_m0_DV),
        .clr_i   (rsp_dv_q[0]),
        .addr_i  (i_m0_address),
        .data_i  (i_m0_data),
        .bhw_i   (i_m0_bhw),
        .write_i (i_m0_write),
        .busy_o  (slot_busy[0]),
        .addr_o  (slot_addr[0]),
        .data_o  (slot_data[0]),
        .bhw_o   (slot_bhw[0]),
        .write_o (slot_write[0])
    );

    bus_request_slot u_slot1 (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .req_i   (i_m1_DV),
        .clr_i   (rsp_dv_q[1]),
        .addr_i  (i_m1_address),
        .data_i  (i_m1_data),
        .bhw_i   (i_m1_bhw),
        .write_i (i_m1_write),
        .busy_o  (slot_busy[1]),
        .addr_o  (slot_addr[1]),
        .data_o  (slot_data[1]),
        .bhw_o   (slot_bhw[1]),
        .write_o (slot_write[1])
    );

    // A slot in its response cycle still reads busy but has already been served.
    assign elig = slot_busy & ~rsp_dv_q;

    always_comb begin
        if (elig == 2'b11) begin
            gnt_sel = ROUND_ROBIN ? ~last_q : 1'b0;
        end else begin
            gnt_sel = elig[1];
        end
        sel_addr  = slot_addr[gnt_q];
        sel_data  = slot_data[gnt_q];
        sel_bhw   = slot_bhw[gnt_q];
        sel_write = slot_write[gnt_q];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= StDrain;
            drain_cnt_q   <= '0;
            last_q        <= 1'b1;
            gnt_q         <= 1'b0;
            rsp_dv_q      <= '0;
            rsp_err_q     <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
            mem_dv_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_bhw_q     <= '0;
            mem_write_q   <= 1'b0;
        end else begin
            rsp_dv_q  <= '0;
            rsp_err_q <= '0;
            mem_dv_q  <= 1'b0;
            unique case (state_q)
                StDrain: begin
                    // A late response from a transaction cut off by reset ends the drain early
                    // and is dropped.
                    if (i_mem_DV || drain_cnt_q == DrainLast) begin
                        state_q <= StIdle;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (elig != 2'b00) begin
                        gnt_q   <= gnt_sel;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (bhw_legal(sel_bhw)) begin
                        mem_dv_q    <= 1'b1;
                        mem_addr_q  <= sel_addr;
                        mem_data_q  <= sel_data;
                        mem_bhw_q   <= sel_bhw;
                        mem_write_q <= sel_write;
                        state_q     <= StWait;
                    end else begin
                        rsp_dv_q[gnt_q]   <= 1'b1;
                        rsp_err_q[gnt_q]  <= 1'b1;
                        rsp_data_q[gnt_q] <= '0;
                        last_q            <= gnt_q;
                        state_q           <= StIdle;
                    end
                end
                StWait: begin
                    if (i_mem_DV) begin
                        rsp_dv_q[gnt_q]   <= 1'b1;
                        rsp_data_q[gnt_q] <= i_mem_data;
                        last_q            <= gnt_q;
                        state_q           <= StIdle;
                    end
                end
                default: state_q <= StDrain;
            endcase
        end
    end

    assign o_m0_data     = rsp_data_q[0];
    assign o_m0_DV       = rsp_dv_q[0];
    assign o_m0_err      = rsp_err_q[0];
    assign o_m0_busy     = slot_busy[0];
    assign o_m1_data     = rsp_data_q[1];
    assign o_m1_DV       = rsp_dv_q[1];
    assign o_m1_err      = rsp_err_q[1];
    assign o_m1_busy     = slot_busy[1];
    assign o_mem_DV      = mem_dv_q;
    assign o_mem_address = mem_addr_q;
    assign o_mem_data    = mem_data_q;
    assign o_mem_bhw     = mem_bhw_q;
    assign o_mem_write   = mem_write_q;

endmodule
